// File: rtl/bounce_gen_if.sv
// Handshake bundle for the bounce generator: burst request in, noisy level
// and status out.
interface bounce_gen_if;
   logic       start;
   logic       target;
   logic [3:0] num_glitches;
   logic       button;
   logic       busy;
   logic       done;
   logic [7:0] edge_count;

   modport master (
      output start, target, num_glitches,
      input  button, busy, done, edge_count
   );

   modport slave (
      input  start, target, num_glitches,
      output button, busy, done, edge_count
   );
endinterface

// File: rtl/bounce_gen.sv
// Contact-bounce stimulus generator: emits num_glitches pseudo-random bounce
// pairs, then holds the target level for SETTLE_CYCLES before pulsing done.
module bounce_gen #(
   parameter int         SETTLE_CYCLES = 16,
   parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
   input  logic         clk,
   input  logic         rst,
   bounce_gen_if.slave  bus
);

   // An all-zero seed would lock the LFSR, so it is forced to 1.
   localparam logic [7:0] SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
   localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, BOUNCE_A, BOUNCE_B, SETTLE, DONE} state_t;

   state_t     r_state;
   logic [7:0] r_lfsr;
   logic [7:0] r_cnt;
   logic [7:0] r_edge;
   logic [3:0] r_glitch;
   logic [3:0] r_ng;
   logic       r_target;
   logic       r_button;
   logic       r_btn_q;
   logic       r_busy;
   logic       r_done;

   logic       w_fb;
   logic [7:0] w_ph_len;
   logic [3:0] w_glitch_inc;

   assign w_fb         = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
   assign w_ph_len     = {6'd0, r_lfsr[1:0]};
   assign w_glitch_inc = r_glitch + 4'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_lfsr   <= SEED;
         r_cnt    <= 8'd0;
         r_edge   <= 8'd0;
         r_glitch <= 4'd0;
         r_ng     <= 4'd0;
         r_target <= 1'b0;
         r_button <= 1'b0;
         r_btn_q  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_lfsr  <= {r_lfsr[6:0], w_fb};
         r_btn_q <= r_button;
         r_done  <= 1'b0;
         // Count a transition one cycle after the button register changes.
         if (r_button != r_btn_q && r_edge != 8'hFF)
            r_edge <= r_edge + 8'd1;

         // r_cnt holds the remaining extra cycles of the current phase.
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_target <= bus.target;
                  r_ng     <= bus.num_glitches;
                  r_glitch <= 4'd0;
                  r_edge   <= 8'd0;
                  r_busy   <= 1'b1;
                  r_button <= bus.target;
                  if (bus.num_glitches == 4'd0) begin
                     r_state <= SETTLE;
                     r_cnt   <= SETTLE_LD;
                  end else begin
                     r_state <= BOUNCE_A;
                     r_cnt   <= w_ph_len;
                  end
               end
            end
            BOUNCE_A: begin
               if (r_cnt == 8'd0) begin
                  r_state  <= BOUNCE_B;
                  r_button <= ~r_target;
                  r_cnt    <= w_ph_len;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            BOUNCE_B: begin
               if (r_cnt == 8'd0) begin
                  r_glitch <= w_glitch_inc;
                  r_button <= r_target;
                  if (w_glitch_inc == r_ng) begin
                     r_state <= SETTLE;
                     r_cnt   <= SETTLE_LD;
                  end else begin
                     r_state <= BOUNCE_A;
                     r_cnt   <= w_ph_len;
                  end
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            SETTLE: begin
               if (r_cnt == 8'd0) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.button     = r_button;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.edge_count = r_edge;

endmodule

// File: tb/tb_bounce_gen.sv
// Scoreboard bench for bounce_gen: stimulus queues expected burst results,
// a negedge monitor checks each done pulse and every bounce phase length.
module tb_bounce_gen;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bounce_gen_if bus();

   bounce_gen #(.SETTLE_CYCLES(16), .LFSR_SEED(8'h00)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic tgt;
      int   edges;
      int   busy_len;   // -1: not checked
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   n_push = 0;
   int   n_done = 0;
   int   cyc = 0;
   int   t_start = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic m_b;
   logic m_prev = 1'b0;
   bit   m_in = 1'b0;
   int   m_run = 0;
   int   m_tr = 0;
   int   m_busy = 0;
   logic [4:0] m_mask = 5'd0;
   exp_t m_e;

   always @(negedge clk) begin
      m_b = bus.button;
      if (bus.busy === 1'b1 && !m_in) begin
         m_in   = 1'b1;
         m_busy = 0;
         m_run  = 0;
         m_tr   = (m_b !== m_prev) ? 1 : 0;
      end else if (m_in && m_b !== m_prev) begin
         m_tr++;
         chk("phase_len_1to4", (m_run >= 1 && m_run <= 4) ? 1 : 0, 1);
         if (m_run >= 1 && m_run <= 4) m_mask[m_run] = 1'b1;
         m_run = 0;
      end
      if (m_in) begin
         m_run++;
         if (bus.busy === 1'b1) m_busy++;
      end
      if (bus.done === 1'b1) begin
         n_done++;
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 0, 1);
         end else begin
            m_e = exp_q.pop_front();
            chk("done_button", m_b, m_e.tgt);
            chk("done_edge_count", bus.edge_count, m_e.edges);
            chk("observed_transitions", m_tr, m_e.edges);
            chk("settle_run", m_run - 1, 16);
            chk("busy_at_done", bus.busy, 0);
            if (m_e.busy_len >= 0) chk("busy_len", m_busy, m_e.busy_len);
         end
         m_in = 1'b0;
      end else if (m_in && bus.busy !== 1'b1) begin
         m_in = 1'b0;   // burst aborted by reset
      end
      m_prev = m_b;
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_burst(input logic t, input int ng, input int edges,
                              input int blen, input bit push);
      bus.start        = 1'b1;
      bus.target       = t;
      bus.num_glitches = 4'(ng);
      if (push) begin
         exp_q.push_back('{t, edges, blen});
         n_push++;
      end
      t_start = cyc;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int k = 0;
      while (bus.done !== 1'b1 && k < 2000) begin
         tick();
         k++;
      end
      chk(name, (k < 2000) ? 1 : 0, 1);
   endtask

   int d_ref, d_run, k;

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.target = 1'b0;
      bus.num_glitches = 4'd0;
      tick(2);
      chk("rst_button", bus.button, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_edge_count", bus.edge_count, 0);
      rst = 1'b0;
      tick();

      // Rise with no glitches: done 17 edges after the start edge.
      start_burst(1'b1, 0, 1, 16, 1'b1);
      chk("ng0_busy_n1", bus.busy, 1);
      chk("ng0_button_n1", bus.button, 1);
      wait_done("ng0_timeout");
      chk("ng0_done_latency", cyc - t_start, 17);
      tick();

      // Falling burst from 1, rising burst from 0, same-level zero-glitch burst.
      start_burst(1'b0, 10, 21, -1, 1'b1);
      wait_done("fall10_timeout");
      tick();
      start_burst(1'b1, 10, 21, -1, 1'b1);
      wait_done("rise10_timeout");
      tick();
      start_burst(1'b1, 0, 0, 16, 1'b1);
      wait_done("same_level_timeout");
      tick();

      // Reference run, then the same run with stray start pulses.
      rst = 1'b1; tick(); rst = 1'b0; tick(3);
      start_burst(1'b0, 5, 10, -1, 1'b1);
      wait_done("ref_timeout");
      d_ref = cyc - t_start;
      tick();
      rst = 1'b1; tick(); rst = 1'b0; tick(3);
      start_burst(1'b0, 5, 10, -1, 1'b1);
      k = 0;
      while (bus.button !== 1'b1 && k < 50) begin tick(); k++; end
      chk("reach_bounce_b", (k < 50) ? 1 : 0, 1);
      bus.start = 1'b1; bus.target = 1'b1; bus.num_glitches = 4'd0;
      tick();
      bus.start = 1'b0;
      wait_done("dist_timeout");
      d_run = cyc - t_start;
      chk("dist_done_timing", d_run, d_ref);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("start_in_done_busy", bus.busy, 0);
      tick();
      chk("start_in_done_busy2", bus.busy, 0);
      chk("start_in_done_edges", bus.edge_count, 10);
      chk("start_in_done_button", bus.button, 0);

      // Abort a 15-glitch burst in BOUNCE_A.
      start_burst(1'b1, 15, 0, -1, 1'b0);
      chk("abort_in_bounce_a", bus.button, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_button", bus.button, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      start_burst(1'b0, 0, 0, 16, 1'b1);
      wait_done("post_abort_timeout");
      chk("post_abort_latency", cyc - t_start, 17);
      tick();

      // Back-to-back 15-glitch bursts alternating target.
      start_burst(1'b1, 15, 31, -1, 1'b1);
      wait_done("b2b1_timeout");
      tick();
      start_burst(1'b0, 15, 31, -1, 1'b1);
      wait_done("b2b2_timeout");
      tick(2);

      chk("phase_len_variety", ($countones(m_mask) >= 2) ? 1 : 0, 1);
      chk("queue_drained", exp_q.size(), 0);
      chk("done_pulses", n_done, n_push);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bounce_gen.md
BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16, cycles the final level is held before done; legal range 1-255.
REQ-002 SHALL have parameter LFSR_SEED, default 8'hA5, LFSR reset value; a value of 0 SHALL be replaced by 8'h01.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a bounce burst; sampled only in IDLE.
REQ-006 SHALL have port target  input  1  final settled level of the burst; captured with start.
REQ-007 SHALL have port num_glitches  input  4  count of bounce pairs before settling; captured with start.
REQ-008 SHALL have port button  output  1  registered noisy level, fed to a debouncer's button input.
REQ-009 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse when settling completes.
REQ-011 SHALL have port edge_count  output  8  button transitions since the last accepted start; saturates at 255.

Function
REQ-012 SHALL implement FSM states IDLE, BOUNCE_A, BOUNCE_B, SETTLE, DONE.
REQ-013 SHALL run an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, that advances every non-reset cycle in all states.
REQ-014 In IDLE, button SHALL hold its last value and busy SHALL be 0.
REQ-015 When start=1 in IDLE at cycle N, the block SHALL capture target and num_glitches, clear edge_count, and assert busy at N+1.
REQ-016 If the captured num_glitches is 0, the FSM SHALL go to SETTLE with button=target at N+1.
REQ-017 If the captured num_glitches is greater than 0, the FSM SHALL go to BOUNCE_A at N+1.
REQ-018 BOUNCE_A SHALL drive button=target; BOUNCE_B SHALL drive button=~target.
REQ-019 Each BOUNCE phase SHALL last 1+lfsr[1:0] cycles (1-4), using the LFSR value at the cycle the phase is entered.
REQ-020 A glitch counter SHALL increment at the end of each BOUNCE_B phase.
REQ-021 At the end of each BOUNCE_B phase, if the glitch counter equals num_glitches, the FSM SHALL enter SETTLE; otherwise it SHALL re-enter BOUNCE_A.
REQ-022 SETTLE SHALL drive button=target for exactly SETTLE_CYCLES cycles, then enter DONE.
REQ-023 DONE SHALL last 1 cycle with done=1, busy=0, button=target, then return to IDLE.
REQ-024 start SHALL be ignored when the FSM is not in IDLE, including the DONE cycle; it SHALL have no effect on any output or counter.
REQ-025 edge_count SHALL increment on each cycle in which the registered button differs from its previous value, and SHALL hold at 255.
REQ-026 If target equals the pre-start button level and num_glitches=0, there SHALL be no transition and edge_count SHALL stay 0.
REQ-027 Total transitions per burst SHALL equal 2*num_glitches, plus 1 if the pre-start level differs from target.
REQ-028 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-029 When rst=1, on the next edge: button=0, busy=0, done=0, edge_count=0, FSM=IDLE, glitch counter=0, LFSR=LFSR_SEED (or 8'h01 if the seed is 0).
REQ-030 rst SHALL take priority over start in the same cycle.
REQ-031 rst asserted mid-burst SHALL abort the burst with no done pulse.
REQ-032 A start accepted after rst is released SHALL behave per REQ-015.

Verification
REQ-033 Reset then start with target=1, num_glitches=0 -> button rises at N+1; done at N+1+16; edge_count=1; busy high for exactly 16 cycles.
REQ-034 Start with target=1, num_glitches=10 from button=0 -> 21 transitions; last 16 cycles before done are button=1; every phase is 1-4 cycles; edge_count=21.
REQ-035 Start with target=0, num_glitches=10 from button=1 -> mirror of REQ-034: 21 transitions; settles at 0; done once.
REQ-036 Pulse start during BOUNCE_B and during DONE -> ignored: transition count and done timing are identical to an undisturbed run.
REQ-037 Assert rst for 1 cycle during BOUNCE_A of a 15-glitch burst -> next cycle button=0, busy=0, no done; a following start with num_glitches=0 and target=0 gives done at N+1+16 and edge_count=0.
REQ-038 Two back-to-back 15-glitch bursts alternating target, with LFSR_SEED=0 -> LFSR never locks at 0; both bursts complete; done pulses twice; edge_count is 31 after each burst.
